priority_encoder_4to2_sync: RTL and testbench



---
 rtl/priority_encoder_4to2_sync.sv | 63 ++++++
 tb/tb_priority_encoder_4to2_sync.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_4to2_sync.sv
// Registered 4-to-2 priority encoder: D[3] wins, with valid, one-hot grant and
// a multiple-request flag, all driven straight from flops.
module priority_encoder_4to2_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] D,
    output logic [1:0] Y,
    output logic       valid,
    output logic [3:0] grant,
    output logic       multi
);

    function automatic logic [1:0] prio_index(input logic [3:0] req);
        logic [1:0] idx;
        if (req[3])      idx = 2'd3;
        else if (req[2]) idx = 2'd2;
        else if (req[1]) idx = 2'd1;
        else             idx = 2'd0;
        return idx;
    endfunction

    function automatic logic [3:0] one_hot(input logic [1:0] idx, input logic any);
        return any ? (4'b0001 << idx) : 4'b0000;
    endfunction

    // Clearing the lowest set bit leaves something only when two or more were set.
    function automatic logic multi_req(input logic [3:0] req);
        return (req & (req - 4'd1)) != 4'd0;
    endfunction

    logic [1:0] y_p0;
    logic       vld_p0;
    logic [3:0] grant_p0;
    logic       multi_p0;

    logic [1:0] y_nxt;
    logic       vld_nxt;

    assign y_nxt   = prio_index(D);
    assign vld_nxt = |D;

    // Stage p0: sample request vector
    always_ff @(posedge clk) begin
        if (rst) begin
            y_p0     <= 2'b00;
            vld_p0   <= 1'b0;
            grant_p0 <= 4'b0000;
            multi_p0 <= 1'b0;
        end else if (en) begin
            y_p0     <= y_nxt;
            vld_p0   <= vld_nxt;
            grant_p0 <= one_hot(y_nxt, vld_nxt);
            multi_p0 <= multi_req(D);
        end
    end

    assign Y     = y_p0;
    assign valid = vld_p0;
    assign grant = grant_p0;
    assign multi = multi_p0;

endmodule

// File: tb/tb_priority_encoder_4to2_sync.sv
// Directed and exhaustive bench for priority_encoder_4to2_sync.
module tb_priority_encoder_4to2_sync;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] D;
    logic [1:0] Y;
    logic       valid;
    logic [3:0] grant;
    logic       multi;

    int n_checks = 0;
    int n_fail   = 0;

    priority_encoder_4to2_sync dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .D     (D),
        .Y     (Y),
        .valid (valid),
        .grant (grant),
        .multi (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Packed observation: {Y, valid, grant, multi}
    function automatic logic [7:0] observed();
        return {Y, valid, grant, multi};
    endfunction

    // Advance one active edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        rst = 1'b1; en = 1'b1; D = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            obs = observed();
            n_checks++;
            if (obs !== 8'b00_0_0000_0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got Y=%b valid=%b grant=%b multi=%b, want 00 0 0000 0",
                         i, obs[7:6], obs[5], obs[4:1], obs[0]);
            end
        end
        rst = 1'b0;
        tick();
        obs = observed();
        n_checks++;
        if (obs !== 8'b11_1_1000_1) begin
            n_fail++;
            $display("FAIL reset_release: got Y=%b valid=%b grant=%b multi=%b, want 11 1 1000 1",
                     obs[7:6], obs[5], obs[4:1], obs[0]);
        end
    endtask

    task automatic test_single_bits();
        logic [3:0] vec [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [7:0] exp [5] = '{8'b00_0_0000_0, 8'b00_1_0001_0, 8'b01_1_0010_0,
                                8'b10_1_0100_0, 8'b11_1_1000_0};
        logic [7:0] obs;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            D = vec[i];
            tick();
            obs = observed();
            n_checks++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL single_bit D=%b: got {Y,valid,grant,multi}=%b, want %b", vec[i], obs, exp[i]);
            end
        end
    endtask

    task automatic test_priority();
        logic [3:0] vec [3] = '{4'b1010, 4'b0111, 4'b1100};
        logic [7:0] exp [3] = '{8'b11_1_1000_1, 8'b10_1_0100_1, 8'b11_1_1000_1};
        logic [7:0] obs;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            D = vec[i];
            tick();
            obs = observed();
            n_checks++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL priority D=%b: got {Y,valid,grant,multi}=%b, want %b", vec[i], obs, exp[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [7:0] obs;
        en = 1'b1; D = 4'b0010;
        tick();
        obs = observed();
        n_checks++;
        if (obs !== 8'b01_1_0010_0) begin
            n_fail++;
            $display("FAIL hold_load: got %b, want 01100100", obs);
        end
        en = 1'b0; D = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = observed();
            n_checks++;
            if (obs !== 8'b01_1_0010_0) begin
                n_fail++;
                $display("FAIL hold_cycle[%0d]: got %b, want 01100100", i, obs);
            end
        end
        en = 1'b1;
        tick();
        obs = observed();
        n_checks++;
        if (obs !== 8'b11_1_1000_0) begin
            n_fail++;
            $display("FAIL hold_reenable: got %b, want 11110000", obs);
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] obs;
        en = 1'b1; D = 4'b0100;
        tick();
        rst = 1'b1; D = 4'b1000;
        tick();
        obs = observed();
        n_checks++;
        if (obs !== 8'b00_0_0000_0) begin
            n_fail++;
            $display("FAIL midstream_reset: got %b, want 00000000", obs);
        end
        en = 1'b0; D = 4'b1111;
        tick();
        obs = observed();
        n_checks++;
        if (obs !== 8'b00_0_0000_0) begin
            n_fail++;
            $display("FAIL reset_with_en_low: got %b, want 00000000", obs);
        end
        rst = 1'b0; en = 1'b1; D = 4'b0001;
        tick();
        obs = observed();
        n_checks++;
        if (obs !== 8'b00_1_0001_0) begin
            n_fail++;
            $display("FAIL post_reset_load: got %b, want 00100010", obs);
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] obs;
        logic [7:0] exp;
        logic [1:0] m_idx;
        logic [3:0] m_grant;
        logic       m_any;
        logic       m_multi;
        en = 1'b1;
        for (int v = 0; v < 16; v++) begin
            D = v[3:0];
            // Model: scan upward so the highest set bit is the last one kept.
            m_idx = 2'd0;
            m_any = 1'b0;
            for (int b = 0; b < 4; b++) begin
                if (D[b]) begin
                    m_idx = b[1:0];
                    m_any = 1'b1;
                end
            end
            m_grant = 4'b0000;
            if (m_any) m_grant[m_idx] = 1'b1;
            m_multi = ($countones(D) >= 2);
            exp = {m_idx, m_any, m_grant, m_multi};
            tick();
            obs = observed();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL exhaustive D=%b: got %b, want %b", D, obs, exp);
            end
            @(negedge clk);
            obs = observed();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL exhaustive_stable D=%b: got %b mid-cycle, want %b", D, obs, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; D = 4'b0000;
        #2;
        test_reset();
        test_single_bits();
        test_priority();
        test_hold();
        test_reset_midstream();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
